mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Samples exe results
//  (writeback + memory request), runs loads/stores over a req/ack data bus with
//  byte-lane steering, and presents registered writeback results to mem_wb.
//  Stalls the upstream pipeline through pipe_ctrl while a bus transaction is open.
// PARAMETERS
//  DATA_WIDTH   32   data/bus width (fixed 32; byte lanes assume 4)
//  ADDR_WIDTH   32   byte address width
//  RADDR_WIDTH  5    register-file address width
//  TIMEOUT      255  max BUS-state cycles without dbus_ack_i before abort (>=1)
// PORTS
//  clk_i         in   1            clock, all state on rising edge
//  rst_i         in   1            reset, synchronous, active-high
//  mem_we_i      in   1            exe store strobe (informational; mem_op_i governs)
//  mem_addr_i    in   ADDR_WIDTH   exe byte address
//  mem_data_i    in   DATA_WIDTH   exe store data (unaligned, low bits)
//  mem_op_i      in   4            `MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW from defines.v
//  reg_waddr_i   in   RADDR_WIDTH  exe writeback address
//  reg_we_i      in   1            exe writeback enable
//  reg_wdata_i   in   DATA_WIDTH   exe writeback data (non-load ops)
//  flush_i       in   1            pipe_ctrl: sample a bubble instead of inputs
//  dbus_req_o    out  1            bus request, held until ack or abort
//  dbus_we_o     out  1            1=write
//  dbus_addr_o   out  ADDR_WIDTH   word-aligned address ({addr[31:2],2'b00})
//  dbus_wdata_o  out  DATA_WIDTH   lane-replicated store data
//  dbus_be_o     out  4            byte enables
//  dbus_rdata_i  in   DATA_WIDTH   read data, valid with dbus_ack_i
//  dbus_ack_i    in   1            transaction complete
//  stall_o       out  1            to pipe_ctrl: hold exe inputs
//  reg_waddr_o   out  RADDR_WIDTH  to mem_wb
//  reg_we_o      out  1            to mem_wb
//  reg_wdata_o   out  DATA_WIDTH   to mem_wb
//  misalign_o    out  1            1-cycle pulse: misaligned access dropped
//  bus_err_o     out  1            1-cycle pulse: bus timeout abort
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-BUS drops dbus_req_o
//    next cycle; in-flight result discarded, no writeback.
//  - States: IDLE, BUS. stall_o = (state==BUS) (combinational, includes ack cycle).
//  - IDLE sample edge: flush_i=1 or mem_op_i=`MEM_NOP (non-memory) -> wb outputs <= inputs
//    (flush: reg_we_o<=0, waddr/wdata<=0); stay IDLE. 1-cycle latency.
//  - IDLE, load/store op, aligned: latch op/addr/data/waddr; drive bus regs; wb outputs
//    <= bubble (reg_we_o=0); -> BUS. dbus_req_o high from next cycle.
//  - Misaligned (H ops addr[0]!=0; W ops addr[1:0]!=0): no bus access, bubble, misalign_o=1
//    next cycle, stay IDLE.
//  - BUS: bus outputs stable; counter++ each cycle. Edge with dbus_ack_i=1: req<=0,
//    -> IDLE; load: reg_we_o<=1, reg_waddr_o<=latched, reg_wdata_o<=extracted; store:
//    reg_we_o<=0. Counter reaching TIMEOUT w/o ack: req<=0, bus_err_o pulse, bubble, -> IDLE.
//    Ack and timeout same cycle: ack wins. flush_i ignored in BUS.
//  - Stores: SB be=1<<a[1:0], wdata={4{d[7:0]}}; SH be=a[1]?4'b1100:4'b0011, wdata={2{d[15:0]}};
//    SW be=4'hF, wdata=d. Loads: be as above, dbus_we_o=0.
//  - Load extract: byte lane a[1:0]*8, half lane a[1]*16; LB/LH sign-extend, LBU/LHU zero-extend.
//  - Loads with reg_waddr_i==0 run the bus access; reg_we_o forced 0.
// TESTING
//  - ADDI result (mem_op=NOP, we=1, waddr=5, wdata=0x12) -> next cycle reg_we_o=1, waddr 5,
//    wdata 0x12; stall_o=0; no dbus_req_o.
//  - LB addr=0x1003, rdata=0x80FF_FF7F, ack after 3 cycles -> dbus_addr 0x1000, be 4'b1000,
//    stall_o 4 cycles, then wdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
//  - SH addr=0x2002 data=0xDEAD_BEEF, ack 1st cycle -> be 4'b1100, wdata 0xBEEF_BEEF,
//    dbus_we_o=1, reg_we_o=0.
//  - LW addr=0x3001 -> no req, misalign_o 1 cycle, reg_we_o=0, stall_o=0.
//  - TIMEOUT=4, SW never acked -> req 4 cycles, bus_err_o pulse, IDLE, next instr accepted.
//  - rst_i high during BUS -> req low next cycle, all outputs 0; flush_i in IDLE -> bubble.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: passes non-memory results through to mem_wb, and runs loads and
// stores over a req/ack data bus with byte-lane steering while stalling the upstream pipe.
module mem_access #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5,
   parameter int TIMEOUT     = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   mem_we_i,
   input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
   input  logic [DATA_WIDTH-1:0]  mem_data_i,
   input  logic [3:0]             mem_op_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   reg_we_i,
   input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
   input  logic                   flush_i,
   output logic                   dbus_req_o,
   output logic                   dbus_we_o,
   output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
   output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
   output logic [3:0]             dbus_be_o,
   input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
   input  logic                   dbus_ack_i,
   output logic                   stall_o,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   reg_we_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o,
   output logic                   misalign_o,
   output logic                   bus_err_o
);

   localparam logic [3:0] MEM_NOP = 4'd0;
   localparam logic [3:0] MEM_LB  = 4'd1;
   localparam logic [3:0] MEM_LH  = 4'd2;
   localparam logic [3:0] MEM_LW  = 4'd3;
   localparam logic [3:0] MEM_LBU = 4'd4;
   localparam logic [3:0] MEM_LHU = 4'd5;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUS  = 1'b1;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [0:0]             state;
   logic [CNT_W-1:0]       tmo_cnt;
   logic [3:0]             op_p1;
   logic [1:0]             lane_p1;
   logic [RADDR_WIDTH-1:0] waddr_p1;

   // The store strobe is redundant with mem_op_i, which alone selects the access type.
   logic unused_mem_we;
   assign unused_mem_we = mem_we_i;

   function automatic logic is_load(input logic [3:0] op);
      return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
      if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return a[0];
      if (op inside {MEM_LW, MEM_SW})          return a != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] a);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << a;
         MEM_LH, MEM_LHU, MEM_SH: return a[1] ? 4'b1100 : 4'b0011;
         default:                 return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [3:0] op,
                                                        input logic [DATA_WIDTH-1:0] d);
      case (op)
         MEM_SB:  return {4{d[7:0]}};
         MEM_SH:  return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [3:0] op,
                                                          input logic [1:0] a,
                                                          input logic [DATA_WIDTH-1:0] rd);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = rd[{a, 3'b000} +: 8];
      h = rd[{a[1], 4'b0000} +: 16];
      case (op)
         MEM_LB:  return {{(DATA_WIDTH-8){b[7]}}, b};
         MEM_LBU: return {{(DATA_WIDTH-8){1'b0}}, b};
         MEM_LH:  return {{(DATA_WIDTH-16){h[15]}}, h};
         MEM_LHU: return {{(DATA_WIDTH-16){1'b0}}, h};
         default: return rd;
      endcase
   endfunction

   assign stall_o = (state == S_BUS);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         tmo_cnt      <= '0;
         op_p1        <= MEM_NOP;
         lane_p1      <= '0;
         waddr_p1     <= '0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_wdata_o <= '0;
         dbus_be_o    <= '0;
         reg_waddr_o  <= '0;
         reg_we_o     <= 1'b0;
         reg_wdata_o  <= '0;
         misalign_o   <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               tmo_cnt <= '0;
               if (flush_i) begin
                  reg_we_o    <= 1'b0;
                  reg_waddr_o <= '0;
                  reg_wdata_o <= '0;
               end else if (is_load(mem_op_i) || is_store(mem_op_i)) begin
                  reg_we_o    <= 1'b0;
                  reg_waddr_o <= '0;
                  reg_wdata_o <= '0;
                  if (misaligned(mem_op_i, mem_addr_i[1:0])) begin
                     misalign_o <= 1'b1;
                  end else begin
                     op_p1        <= mem_op_i;
                     lane_p1      <= mem_addr_i[1:0];
                     waddr_p1     <= reg_waddr_i;
                     dbus_req_o   <= 1'b1;
                     dbus_we_o    <= is_store(mem_op_i);
                     dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                     dbus_be_o    <= byte_en(mem_op_i, mem_addr_i[1:0]);
                     dbus_wdata_o <= lane_wdata(mem_op_i, mem_data_i);
                     state        <= S_BUS;
                  end
               end else begin
                  reg_we_o    <= reg_we_i;
                  reg_waddr_o <= reg_waddr_i;
                  reg_wdata_o <= reg_wdata_i;
               end
            end
            S_BUS: begin
               // Ack takes priority over a timeout expiring on the same edge.
               if (dbus_ack_i) begin
                  dbus_req_o <= 1'b0;
                  state      <= S_IDLE;
                  if (is_load(op_p1)) begin
                     reg_we_o    <= (waddr_p1 != '0);
                     reg_waddr_o <= waddr_p1;
                     reg_wdata_o <= load_extract(op_p1, lane_p1, dbus_rdata_i);
                  end else begin
                     reg_we_o    <= 1'b0;
                     reg_waddr_o <= '0;
                     reg_wdata_o <= '0;
                  end
               end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  dbus_req_o  <= 1'b0;
                  bus_err_o   <= 1'b1;
                  reg_we_o    <= 1'b0;
                  reg_waddr_o <= '0;
                  reg_wdata_o <= '0;
                  state       <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: an instruction-level model predicts the per-cycle
// output trace of each issued instruction, and one process compares it on every negedge.
module tb_mem_access;

   localparam int TMO = 4;

   localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                          LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_we_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_data_i = '0;
   logic [3:0]  mem_op_i = '0;
   logic [4:0]  reg_waddr_i = '0;
   logic        reg_we_i = 1'b0;
   logic [31:0] reg_wdata_i = '0;
   logic        flush_i = 1'b0;
   logic        dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_rdata_i = '0;
   logic        dbus_ack_i = 1'b0;
   logic        stall_o;
   logic [4:0]  reg_waddr_o;
   logic        reg_we_o;
   logic [31:0] reg_wdata_o;
   logic        misalign_o, bus_err_o;

   always #5 clk = ~clk;

   mem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_data_i(mem_data_i), .mem_op_i(mem_op_i), .reg_waddr_i(reg_waddr_i),
      .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .flush_i(flush_i),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_rdata_i(dbus_rdata_i),
      .dbus_ack_i(dbus_ack_i), .stall_o(stall_o), .reg_waddr_o(reg_waddr_o),
      .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic        stall, req, bwe, chk_wd;
      logic [31:0] baddr, bwdata;
      logic [3:0]  be;
      logic        rwe;
      logic [4:0]  rwa;
      logic [31:0] rwd;
      logic        mis, berr;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   function automatic int m_size(input logic [3:0] op);
      if (op == LB || op == LBU || op == SB) return 1;
      if (op == LH || op == LHU || op == SH) return 2;
      if (op == LW || op == SW)              return 4;
      return 0;
   endfunction

   function automatic bit m_store(input logic [3:0] op);
      return op == SB || op == SH || op == SW;
   endfunction

   function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
      int s = m_size(op);
      return 4'(((1 << s) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
      if (m_size(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (m_size(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_extract(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
      int bits = 8 * m_size(op);
      logic [31:0] v;
      if (bits == 32) return rd;
      v = (rd >> (8 * (a % 4))) & ((32'd1 << bits) - 1);
      if ((op == LB || op == LH) && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   function automatic exp_t m_wb(input int c, input logic rwe, input logic [4:0] rwa,
                                 input logic [31:0] rwd, input logic mis, input logic berr);
      exp_t e;
      e = '0;
      e.cyc = 32'(c); e.rwe = rwe; e.rwa = rwa; e.rwd = rwd; e.mis = mis; e.berr = berr;
      return e;
   endfunction

   // ---------------- compare ----------------
   task automatic check_entry(input exp_t e);
      bit ok;
      ok = stall_o === e.stall && dbus_req_o === e.req && reg_we_o === e.rwe &&
           reg_waddr_o === e.rwa && reg_wdata_o === e.rwd && misalign_o === e.mis &&
           bus_err_o === e.berr;
      if (e.req)
         ok = ok && dbus_we_o === e.bwe && dbus_addr_o === e.baddr && dbus_be_o === e.be &&
              (!e.chk_wd || dbus_wdata_o === e.bwdata);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL trace cyc %0d: got stall=%b req=%b bwe=%b addr=%h be=%b bwd=%h rwe=%b rwa=%0d rwd=%h mis=%b err=%b; want stall=%b req=%b bwe=%b addr=%h be=%b bwd=%h rwe=%b rwa=%0d rwd=%h mis=%b err=%b",
                  e.cyc, stall_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
                  reg_we_o, reg_waddr_o, reg_wdata_o, misalign_o, bus_err_o,
                  e.stall, e.req, e.bwe, e.baddr, e.be, e.bwdata, e.rwe, e.rwa, e.rwd, e.mis,
                  e.berr);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         if (q[0].cyc == 32'(cyc)) begin
            check_entry(q[0]);
            void'(q.pop_front());
         end else if (q[0].cyc < 32'(cyc)) begin
            tests++;
            fails++;
            $display("FAIL trace: entry for cyc %0d never compared (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the edge that starts the
   // instruction's final (result) cycle, so the next call is sampled right after it.
   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] waddr, input logic we, input logic [31:0] wdata,
                        input logic flush, input int ack_d, input logic [31:0] rdata);
      int c0 = cyc;
      int s = m_size(op);
      int n;
      bit acked;
      exp_t e;
      mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = m_store(op);
      reg_waddr_i = waddr; reg_we_i = we; reg_wdata_i = wdata; flush_i = flush;
      dbus_ack_i = 1'b0;
      if (flush) begin
         q.push_back(m_wb(c0 + 1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0));
      end else if (s == 0) begin
         q.push_back(m_wb(c0 + 1, we, waddr, wdata, 1'b0, 1'b0));
      end else if (addr % s != 0) begin
         q.push_back(m_wb(c0 + 1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
      end else begin
         acked = ack_d < TMO;
         n = acked ? ack_d + 1 : TMO;
         for (int i = 0; i < n; i++) begin
            e = m_wb(c0 + 1 + i, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            e.stall = 1'b1; e.req = 1'b1; e.bwe = m_store(op);
            e.baddr = addr - (addr % 4); e.be = m_be(op, addr);
            e.chk_wd = m_store(op); e.bwdata = m_wdata(op, data);
            q.push_back(e);
         end
         if (!acked)
            q.push_back(m_wb(c0 + 1 + n, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1));
         else if (m_store(op))
            q.push_back(m_wb(c0 + 1 + n, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0));
         else
            q.push_back(m_wb(c0 + 1 + n, waddr != 0, waddr, m_extract(op, addr, rdata),
                             1'b0, 1'b0));
         @(posedge clk); #1;
         for (int i = 0; i < n; i++) begin
            // Upstream inputs are scrambled while stalled: they must be ignored.
            mem_op_i = 4'($urandom_range(0, 11)); mem_addr_i = $urandom;
            reg_we_i = 1'($urandom); flush_i = 1'($urandom);
            dbus_ack_i = (i == ack_d);
            dbus_rdata_i = (i == ack_d) ? rdata : $urandom;
            @(posedge clk); #1;
         end
         dbus_ack_i = 1'b0;
         return;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [4:0]  wa;

      // Model pinned against hand-computed values.
      chk("model LB extract", m_extract(LB, 32'h1003, 32'h80FF_FF7F), 32'hFFFF_FF80);
      chk("model LBU extract", m_extract(LBU, 32'h1003, 32'h80FF_FF7F), 32'h0000_0080);
      chk("model LH extract", m_extract(LH, 32'h0002, 32'h8001_1234), 32'hFFFF_8001);
      chk("model LB be", 32'(m_be(LB, 32'h1003)), 32'b1000);
      chk("model SH be", 32'(m_be(SH, 32'h2002)), 32'b1100);
      chk("model SH wdata", m_wdata(SH, 32'hDEAD_BEEF), 32'hBEEF_BEEF);
      chk("model SB wdata", m_wdata(SB, 32'h1234_56A5), 32'hA5A5_A5A5);

      repeat (3) @(posedge clk);
      #1;
      chk("reset req", 32'(dbus_req_o), 0);
      chk("reset stall", 32'(stall_o), 0);
      chk("reset reg_we", 32'(reg_we_o), 0);
      chk("reset wdata", reg_wdata_o, 0);
      chk("reset be", 32'(dbus_be_o), 0);
      rst_i = 1'b0;

      issue(NOP, 0, 0, 5'd5, 1'b1, 32'h12, 1'b0, 0, 0);
      chk("addi reg_we", 32'(reg_we_o), 1);
      chk("addi waddr", 32'(reg_waddr_o), 5);
      chk("addi wdata", reg_wdata_o, 32'h12);
      chk("addi req", 32'(dbus_req_o), 0);

      issue(LB, 32'h1003, 0, 5'd7, 1'b1, 0, 1'b0, 3, 32'h80FF_FF7F);
      chk("lb wdata", reg_wdata_o, 32'hFFFF_FF80);
      chk("lb stall after", 32'(stall_o), 0);
      issue(LBU, 32'h1003, 0, 5'd7, 1'b1, 0, 1'b0, 3, 32'h80FF_FF7F);
      chk("lbu wdata", reg_wdata_o, 32'h0000_0080);
      issue(SH, 32'h2002, 32'hDEAD_BEEF, 5'd3, 1'b0, 0, 1'b0, 0, 0);
      chk("sh reg_we", 32'(reg_we_o), 0);
      issue(LW, 32'h3001, 0, 5'd4, 1'b1, 0, 1'b0, 0, 0);
      chk("lw misalign", 32'(misalign_o), 1);
      chk("lw misalign stall", 32'(stall_o), 0);
      issue(SW, 32'h4000, 32'h1111_2222, 5'd0, 1'b0, 0, 1'b0, 99, 0);
      chk("sw timeout bus_err", 32'(bus_err_o), 1);
      issue(NOP, 0, 0, 5'd9, 1'b1, 32'hABCD, 1'b0, 0, 0);
      chk("after timeout wdata", reg_wdata_o, 32'hABCD);
      issue(LW, 32'h5000, 0, 5'd6, 1'b1, 32'h77, 1'b1, 0, 0);
      chk("flush reg_we", 32'(reg_we_o), 0);
      issue(LW, 32'h6004, 0, 5'd0, 1'b1, 0, 1'b0, 1, 32'hCAFE_F00D);
      chk("load x0 reg_we", 32'(reg_we_o), 0);

      for (int k = 0; k < 400; k++) begin
         op = 4'($urandom_range(0, 11));
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         wa = 5'($urandom);
         if ($urandom_range(0, 7) == 0) wa = 5'd0;
         issue(op, a, $urandom, wa, 1'($urandom), $urandom, $urandom_range(0, 9) == 0,
               $urandom_range(0, 5), $urandom);
      end

      // Reset arriving mid-transaction.
      mem_op_i = SW; mem_addr_i = 32'h40; mem_data_i = 32'h5A5A_5A5A; mem_we_i = 1'b1;
      flush_i = 1'b0; reg_we_i = 1'b0; dbus_ack_i = 1'b0;
      @(posedge clk); #1;
      chk("rst-bus req before", 32'(dbus_req_o), 1);
      chk("rst-bus stall before", 32'(stall_o), 1);
      rst_i = 1'b1; mem_op_i = NOP; mem_we_i = 1'b0;
      @(posedge clk); #1;
      chk("rst-bus req", 32'(dbus_req_o), 0);
      chk("rst-bus stall", 32'(stall_o), 0);
      chk("rst-bus addr", dbus_addr_o, 0);
      chk("rst-bus bwdata", dbus_wdata_o, 0);
      chk("rst-bus reg_we", 32'(reg_we_o), 0);
      chk("rst-bus bus_err", 32'(bus_err_o), 0);
      rst_i = 1'b0;
      @(posedge clk); #1;
      chk("post-rst reg_we", 32'(reg_we_o), 0);
      chk("post-rst req", 32'(dbus_req_o), 0);

      repeat (2) @(posedge clk);
      #1;
      chk("trace drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
